// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared definitions for the data-memory arbiter
package dm_arbiter_pkg;

    localparam int DM_DEPTH_WORDS  = 20;
    localparam int DM_STARVE_LIMIT = 4;

    // Describes the grant taken at the previous edge
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_WR   = 2'd3
    } dm_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - two-port request bus plus data-memory side of the arbiter
interface dm_arbiter_if;
    logic        req0, we0;
    logic [31:0] addr0, wd0;
    logic        req1, we1;
    logic [31:0] addr1, wd1;
    logic        gnt0, gnt1, stall0;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_address, mem_WD;
    logic        mem_write;
    logic [31:0] mem_RD;

    modport slave (
        input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_RD,
        output gnt0, gnt1, stall0, rvalid0, rvalid1, rdata, err,
               mem_address, mem_WD, mem_write
    );

    modport master (
        output req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_RD,
        input  gnt0, gnt1, stall0, rvalid0, rvalid1, rdata, err,
               mem_address, mem_WD, mem_write
    );
endinterface

// File: rtl/dm_arbiter_addr_check.sv
// rtl/dm_arbiter_addr_check.sv - word-aligned, in-range address check for one port
module dm_addr_check
    import dm_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS
) (
    input  logic [31:0] addr_i,
    output logic        valid_o
);
    assign valid_o = (addr_i[1:0] == 2'b00) &&
                     ({2'b00, addr_i[31:2]} < 32'(DEPTH_WORDS));
endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - port-0-priority data-memory arbiter with port-1 anti-starvation
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS  = DM_DEPTH_WORDS,
    parameter int STARVE_LIMIT = DM_STARVE_LIMIT
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_arbiter_if.slave  bus
);
    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    dm_state_e     state_q;
    logic [CW-1:0] starve_cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic        valid0, valid1;
    logic        force1, gnt0, gnt1, gnt_any;
    logic        sel_valid, sel_we;
    logic [31:0] sel_addr, sel_wd;

    dm_addr_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk0 (.addr_i(bus.addr0), .valid_o(valid0));
    dm_addr_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk1 (.addr_i(bus.addr1), .valid_o(valid1));

    // Grants are gated by rst_n so they drop asynchronously with the registers
    assign force1  = bus.req1 && (starve_cnt_q == CNT_MAX);
    assign gnt1    = rst_n && bus.req1 && (!bus.req0 || force1);
    assign gnt0    = rst_n && bus.req0 && !gnt1;
    assign gnt_any = gnt0 || gnt1;

    always_comb begin
        sel_valid = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wd    = '0;
        if (gnt0) begin
            sel_valid = valid0;
            sel_we    = bus.we0;
            sel_addr  = bus.addr0;
            sel_wd    = bus.wd0;
        end else if (gnt1) begin
            sel_valid = valid1;
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wd    = bus.wd1;
        end
    end

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.stall0      = bus.req0 && !gnt0;
    assign bus.mem_address = sel_addr;
    assign bus.mem_WD      = sel_wd;
    assign bus.mem_write   = gnt_any && sel_we && sel_valid;
    assign bus.rvalid0     = (state_q == ST_RD0);
    assign bus.rvalid1     = (state_q == ST_RD1);
    assign bus.rdata       = rdata_q;
    assign bus.err         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (!gnt_any)    state_q <= ST_IDLE;
            else if (sel_we) state_q <= ST_WR;
            else if (gnt0)   state_q <= ST_RD0;
            else             state_q <= ST_RD1;

            // Rejected reads still respond, but with zero data
            if (gnt_any && !sel_we)
                rdata_q <= sel_valid ? bus.mem_RD : 32'h0;
            err_q <= gnt_any && !sel_valid;

            if (gnt1 || !bus.req1)
                starve_cnt_q <= '0;
            else if (starve_cnt_q != CNT_MAX)
                starve_cnt_q <= starve_cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized and directed checks of dm_arbiter against a behavioural model
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int DEPTH = DM_DEPTH_WORDS;
    localparam int LIMIT = DM_STARVE_LIMIT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if bus ();

    dm_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] phys [DEPTH];
    logic [31:0] mmem [DEPTH];

    assign bus.mem_RD = (bus.mem_address[31:2] < 30'(DEPTH)) ?
                        phys[bus.mem_address[31:2]] : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_errors = 0;

    int          m_starve = 0;
    logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        obs_gnt1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            1:       return 32'($urandom_range(DEPTH, DEPTH + 10)) << 2;
            2:       return $urandom;
            default: return 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
    endfunction

    // One cycle: drive after the edge, then check outputs and advance the model at the falling edge
    task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic        g0, g1, gnt, we, ok;
        logic [31:0] a, d;
        @(posedge clk);
        #1;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wd0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wd1 = d1;
        @(negedge clk);
        check("rvalid0", 32'(bus.rvalid0), 32'(exp_rv0));
        check("rvalid1", 32'(bus.rvalid1), 32'(exp_rv1));
        check("rdata", bus.rdata, exp_rdata);
        check("err", 32'(bus.err), 32'(exp_err));

        g1  = r1 && (!r0 || m_starve == LIMIT);
        g0  = r0 && !g1;
        gnt = g0 || g1;
        a   = g0 ? a0 : (g1 ? a1 : 32'h0);
        d   = g0 ? d0 : (g1 ? d1 : 32'h0);
        we  = g0 ? w0 : (g1 && w1);
        ok  = gnt && a % 4 == 0 && a / 4 < DEPTH;
        check("gnt0", 32'(bus.gnt0), 32'(g0));
        check("gnt1", 32'(bus.gnt1), 32'(g1));
        check("stall0", 32'(bus.stall0), 32'(r0 && !g0));
        check("mem_address", bus.mem_address, a);
        check("mem_WD", bus.mem_WD, d);
        check("mem_write", 32'(bus.mem_write), 32'(gnt && we && ok));
        obs_gnt1 = bus.gnt1;

        if (bus.mem_write && bus.mem_address[31:2] < 30'(DEPTH))
            phys[bus.mem_address[31:2]] = bus.mem_WD;
        exp_rv0 = g0 && !we;
        exp_rv1 = g1 && !we;
        if (gnt && !we) exp_rdata = ok ? mmem[a / 4] : 32'h0;
        exp_err = gnt && !ok;
        if (gnt && we && ok) mmem[a / 4] = d;
        m_starve = (g1 || !r1) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int first_g1;
        for (int i = 0; i < DEPTH; i++) begin
            mmem[i] = $urandom;
            phys[i] = mmem[i];
        end
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h4; bus.wd0 = 32'h1234;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h8; bus.wd1 = 32'h0;

        // Reset values with requests pending
        repeat (2) @(negedge clk);
        check("rst_gnt0", 32'(bus.gnt0), 0);
        check("rst_gnt1", 32'(bus.gnt1), 0);
        check("rst_mem_write", 32'(bus.mem_write), 0);
        check("rst_rvalid0", 32'(bus.rvalid0), 0);
        check("rst_rvalid1", 32'(bus.rvalid1), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_err", 32'(bus.err), 0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst_n = 1'b1;
        idle();

        // Port 0 read of address 8 returns the memory word
        mmem[2] = 32'h0000_00AA;
        phys[2] = 32'h0000_00AA;
        step(1, 0, 32'h8, 0, 0, 0, 0, 0);
        idle();
        check("d_read8_rdata", bus.rdata, 32'h0000_00AA);

        // Continuous contention: port 1 forced in on the 5th cycle
        first_g1 = 0;
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
            if (obs_gnt1 && first_g1 == 0) first_g1 = i;
        end
        check("d_starve_first_gnt1", 32'(first_g1), 32'(LIMIT + 1));
        idle();

        // Out-of-range and misaligned writes are rejected
        step(0, 0, 0, 0, 1, 1, 32'h50, 32'hDEAD_BEEF);
        step(1, 1, 32'h06, 32'h5555_5555, 0, 0, 0, 0);
        idle();

        // Alternating reads, no bubble
        step(1, 0, 32'h0C, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h10, 0);
        step(1, 0, 32'h14, 0, 0, 0, 0, 0);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 1), rand_addr(), $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1), rand_addr(), $urandom);
        idle();

        // Reset while a port 0 read is pending
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt0", 32'(bus.gnt0), 0);
        check("mid_rst_mem_write", 32'(bus.mem_write), 0);
        check("mid_rst_rdata", bus.rdata, 0);
        check("mid_rst_err", 32'(bus.err), 0);
        @(posedge clk);
        #1;
        check("mid_rst_rvalid0", 32'(bus.rvalid0), 0);
        @(negedge clk);
        bus.req0 = 1'b0;
        rst_n = 1'b1;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0; m_starve = 0;
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 20, meaning number of 32-bit words in the data memory.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied cycles for port 1 before it is forced to win.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with the data memory.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0, we0  input  1 each  port 0 (pipeline MEM stage) request and write-enable.
REQ-007 addr0, wd0  input  32 each  port 0 byte address and write data.
REQ-008 req1, we1, addr1, wd1  input  1/1/32/32  port 1 (loader/debug) request, write-enable, address and data.
REQ-009 gnt0, gnt1  output  1 each  same-cycle grant; the access is performed at the next rising edge.
REQ-010 stall0  output  1  equal to req0 & ~gnt0.
REQ-011 rvalid0, rvalid1  output  1 each  registered read-data-valid, one cycle after a granted read.
REQ-012 rdata  output  32  registered read data for whichever port has rvalid asserted.
REQ-013 err  output  1  registered pulse, aligned with the response cycle, flagging a rejected access.
REQ-014 mem_address, mem_WD  output  32 each  driven to the data memory from the granted port.
REQ-015 mem_write  output  1  data-memory write strobe.
REQ-016 mem_RD  input  32  combinational read data from the data memory.

Function
REQ-017 SHALL assert at most one of gnt0/gnt1 in any cycle.
REQ-018 Default priority: port 0 wins when req0 is high, unless the force condition of REQ-020 holds.
REQ-019 starve_cnt (width clog2(STARVE_LIMIT+1)): increments when req1 & ~gnt1, saturating at STARVE_LIMIT; clears to 0 on gnt1 or when req1 is low.
REQ-020 When starve_cnt == STARVE_LIMIT and req1 is high, SHALL grant port 1 regardless of req0; stall0 is then high.
REQ-021 FSM states, registered, describing the previous cycle's grant:
- IDLE: no grant.
- RD0 / RD1: read granted to port 0 / port 1.
- WR: any write.
REQ-022 FSM transitions each edge from the current grant: read by port x goes to RDx, a write goes to WR, no grant goes to IDLE.
REQ-023 rvalid0 = (state==RD0); rvalid1 = (state==RD1); rdata holds the mem_RD value captured at the edge that entered RDx.
REQ-024 rdata SHALL hold its last value when neither rvalid is high.
REQ-025 An access is invalid when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-026 For an invalid access:
- the grant is still given;
- mem_write is forced 0;
- err pulses in the next cycle;
- rdata is 0 for a rejected read;
- rvalid is still asserted for a rejected read.
REQ-027 mem_write = granted port's we & access valid.
REQ-028 mem_address and mem_WD follow the granted port; both are 0 when there is no grant.
REQ-029 Read latency is 1 cycle from grant to rvalid; write latency is 0 cycles, committed at the grant edge.
REQ-030 Simultaneous read by port 0 and write by port 1 with starve_cnt < STARVE_LIMIT: port 0 is served; port 1 waits and starve_cnt increments.
REQ-031 Back-to-back grants to alternating ports SHALL produce correctly routed rvalids with no bubble.

Reset
REQ-032 While rst_n is low:
- state = IDLE, starve_cnt = 0;
- rvalid0 = rvalid1 = 0, err = 0, rdata = 0;
- gnt0 = gnt1 = 0, mem_write = 0.
REQ-033 Reset asserted mid-read SHALL drop the pending rvalid; no response is issued after reset releases.

Structure
REQ-034 FSM state encodings, the DEPTH_WORDS default and the STARVE_LIMIT default SHALL reside in a shared definitions include used by the CPU top and the bench.
REQ-035 The address validity check SHALL be one combinational sub-module, dm_addr_check, instantiated once per port.

Verification
REQ-036 Port 0 reads address 8 while mem_RD=0x0000_00AA -> gnt0=1 that cycle; next cycle rvalid0=1, rdata=0x0000_00AA, err=0.
REQ-037 req0 and req1 held high continuously -> gnt1 first asserts on the 5th cycle; starve_cnt then returns to 0; stall0=1 in that cycle only.
REQ-038 Port 1 writes 0xDEADBEEF to address 0x50 (word 20) -> mem_write=0; err=1 in the next cycle.
REQ-039 Port 0 writes to address 0x06 (misaligned) -> mem_write=0; err=1 in the next cycle.
REQ-040 Port 0 read at cycle n, port 1 read at cycle n+1 -> rvalid0 at n+1, rvalid1 at n+2, each with the corresponding data.
REQ-041 rst_n driven low the cycle after a port 0 read grant -> rvalid0 stays 0; all outputs return to reset values asynchronously.
